// File: rtl/pc_redirect_pkg.sv
// pc_redirect_pkg: shared types and constants for the PC redirect unit
package pc_redirect_pkg;
  typedef enum logic [1:0] {RUN, FLUSH, HALT} redirect_state_t;
  typedef logic [2:0] flush_cnt_t;
  localparam int PC_INC = 4;
endpackage

// File: rtl/pc_redirect_unit_if.sv
// pc_redirect_unit_if: fetch-redirect bus; taken_cnt/flush_cyc exist only with PC_REDIRECT_STATS_EN
interface pc_redirect_unit_if #(parameter int PC_W = 32);
  logic stall, JmpSel, halt, resume;
  logic [PC_W-1:0] jmp_target, pc, pc_plus4;
  logic flush, fetch_valid, halted;
`ifdef PC_REDIRECT_STATS_EN
  logic [15:0] taken_cnt, flush_cyc;
  modport master (output stall, JmpSel, jmp_target, halt, resume,
                  input pc, pc_plus4, flush, fetch_valid, halted, taken_cnt, flush_cyc);
  modport slave (input stall, JmpSel, jmp_target, halt, resume,
                 output pc, pc_plus4, flush, fetch_valid, halted, taken_cnt, flush_cyc);
`else
  modport master (output stall, JmpSel, jmp_target, halt, resume,
                  input pc, pc_plus4, flush, fetch_valid, halted);
  modport slave (input stall, JmpSel, jmp_target, halt, resume,
                 output pc, pc_plus4, flush, fetch_valid, halted);
`endif
endinterface

// File: rtl/pc_redirect_unit_pc_reg.sv
// pc_reg: program counter register with load/increment/hold muxing
module pc_reg import pc_redirect_pkg::*; #(
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4
);
  assign pc_plus4 = pc + PC_W'(PC_INC);
  always_ff @(posedge clk)
    if (rst) pc <= RESET_PC;
    else if (load) pc <= din;
    else if (inc) pc <= pc_plus4;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: owns the PC, redirects on taken jumps and squashes wrong-path slots.
// Optional PC_REDIRECT_STATS_EN adds saturating taken_cnt/flush_cyc counters.
module pc_redirect_unit import pc_redirect_pkg::*; #(
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int FLUSH_STAGES = 2
) (
  input logic clk,
  input logic rst,
  pc_redirect_unit_if.slave bus
);
  localparam flush_cnt_t FS = flush_cnt_t'(FLUSH_STAGES);
  redirect_state_t state, state_n;
  flush_cnt_t cnt, cnt_n;
  logic pend, pend_n, active, redirect, inc, flush;
  logic [PC_W-1:0] pend_tgt, pend_tgt_n, tgt, pc, pc_plus4;
  assign active = state != HALT;
  // A live JmpSel is newer than any pending target, so it wins
  assign redirect = active && !bus.stall && (bus.JmpSel || pend);
  assign tgt = bus.JmpSel ? bus.jmp_target : pend_tgt;
  assign inc = active && !bus.stall && !redirect;
  assign flush = state == FLUSH && cnt != '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    pend_n = pend;
    pend_tgt_n = pend_tgt;
    if (state == HALT) state_n = bus.resume ? RUN : HALT;
    else if (bus.stall) begin
      if (bus.JmpSel) begin
        pend_n = 1'b1;
        pend_tgt_n = bus.jmp_target;
      end
    end else if (redirect) begin
      state_n = FLUSH;
      cnt_n = FS;
      pend_n = 1'b0;
    end else if (bus.halt) begin
      state_n = HALT;
      cnt_n = '0;
    end else if (state == FLUSH) begin
      cnt_n = cnt - 1'b1;
      state_n = cnt == 3'd1 ? RUN : FLUSH;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= RUN;
      cnt <= '0;
      pend <= 1'b0;
      pend_tgt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pend <= pend_n;
      pend_tgt <= pend_tgt_n;
    end
  pc_reg #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc_reg (
    .clk(clk), .rst(rst), .load(redirect), .inc(inc), .din(tgt), .pc(pc), .pc_plus4(pc_plus4)
  );
  assign bus.pc = pc;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.flush = flush;
  assign bus.fetch_valid = !rst && active;
  assign bus.halted = state == HALT;
`ifdef PC_REDIRECT_STATS_EN
  logic [15:0] taken_cnt, flush_cyc;
  always_ff @(posedge clk)
    if (rst) begin
      taken_cnt <= '0;
      flush_cyc <= '0;
    end else begin
      if (redirect && !(&taken_cnt)) taken_cnt <= taken_cnt + 16'd1;
      if (flush && !(&flush_cyc)) flush_cyc <= flush_cyc + 16'd1;
    end
  assign bus.taken_cnt = taken_cnt;
  assign bus.flush_cyc = flush_cyc;
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// tb_pc_redirect_unit: directed self-checking bench for pc_redirect_unit
module tb_pc_redirect_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pc_redirect_unit_if #(.PC_W(32)) bus ();
  pc_redirect_unit_if #(.PC_W(8)) bus8 ();
  pc_redirect_unit #(.PC_W(32), .RESET_PC(32'h0), .FLUSH_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  pc_redirect_unit #(.PC_W(8), .RESET_PC(8'h0), .FLUSH_STAGES(2)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.JmpSel = 0; bus.jmp_target = '0; bus.halt = 0; bus.resume = 0;
    bus8.stall = 0; bus8.JmpSel = 0; bus8.jmp_target = '0; bus8.halt = 0; bus8.resume = 0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    idle();
    rst = 1;
    step();
    n_chk++; if (bus.pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", bus.pc); end
    n_chk++; if (bus.flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", bus.flush); end
    n_chk++; if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got %b want 0", bus.halted); end
    n_chk++; if (bus.fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fv got %b want 0", bus.fetch_valid); end
    rst = 0;
    #1;
    n_chk++; if (bus.fetch_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_fv got %b want 1", bus.fetch_valid); end
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_pc += 4;
      n_chk++; if (bus.pc !== exp_pc || bus.fetch_valid !== 1'b1)
        begin n_fail++; $display("FAIL free_run pc %h fv %b want %h fv 1", bus.pc, bus.fetch_valid, exp_pc); end
    end
  endtask

  task automatic test_jump();
    step();
    n_chk++; if (bus.pc !== 32'h10) begin n_fail++; $display("FAIL jump_pre_pc got %h want 10", bus.pc); end
    bus.JmpSel = 1; bus.jmp_target = 32'h100;
    step();
    bus.JmpSel = 0;
    n_chk++; if (bus.pc !== 32'h100 || bus.flush !== 1'b1) begin n_fail++; $display("FAIL jump_tgt pc %h flush %b want 100/1", bus.pc, bus.flush); end
    step();
    n_chk++; if (bus.pc !== 32'h104 || bus.flush !== 1'b1) begin n_fail++; $display("FAIL jump_flush2 pc %h flush %b want 104/1", bus.pc, bus.flush); end
    step();
    n_chk++; if (bus.pc !== 32'h108 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL jump_done pc %h flush %b want 108/0", bus.pc, bus.flush); end
  endtask

  task automatic test_stall_jump();
    bus.stall = 1; bus.JmpSel = 1; bus.jmp_target = 32'h40;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.JmpSel = 0;
      n_chk++; if (bus.pc !== 32'h108 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL stall_hold pc %h flush %b want 108/0", bus.pc, bus.flush); end
    end
    bus.stall = 0;
    step();
    n_chk++; if (bus.pc !== 32'h40 || bus.flush !== 1'b1) begin n_fail++; $display("FAIL stall_redirect pc %h flush %b want 40/1", bus.pc, bus.flush); end
    step();
    step();
    n_chk++; if (bus.pc !== 32'h48 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL stall_done pc %h flush %b want 48/0", bus.pc, bus.flush); end
    bus.stall = 1; bus.JmpSel = 1; bus.jmp_target = 32'h200;
    step();
    bus.jmp_target = 32'h300;
    step();
    bus.JmpSel = 0; bus.stall = 0;
    step();
    n_chk++; if (bus.pc !== 32'h300 || bus.flush !== 1'b1) begin n_fail++; $display("FAIL latest_wins pc %h flush %b want 300/1", bus.pc, bus.flush); end
    step();
    step();
  endtask

  task automatic test_halt();
    bus.JmpSel = 1; bus.jmp_target = 32'h20;
    step();
    bus.JmpSel = 0; bus.halt = 1;
    step();
    bus.halt = 0;
    n_chk++; if (bus.pc !== 32'h24 || bus.halted !== 1'b1 || bus.fetch_valid !== 1'b0 || bus.flush !== 1'b0)
      begin n_fail++; $display("FAIL halt_enter pc %h halted %b fv %b flush %b want 24/1/0/0", bus.pc, bus.halted, bus.fetch_valid, bus.flush); end
    bus.JmpSel = 1; bus.jmp_target = 32'h999;
    for (int i = 0; i < 5; i++) begin
      bus.stall = i[0];
      step();
      n_chk++; if (bus.pc !== 32'h24 || bus.halted !== 1'b1) begin n_fail++; $display("FAIL halt_hold pc %h halted %b want 24/1", bus.pc, bus.halted); end
    end
    bus.JmpSel = 0; bus.stall = 0; bus.resume = 1;
    step();
    bus.resume = 0;
    n_chk++; if (bus.pc !== 32'h24 || bus.halted !== 1'b0 || bus.fetch_valid !== 1'b1)
      begin n_fail++; $display("FAIL resume pc %h halted %b fv %b want 24/0/1", bus.pc, bus.halted, bus.fetch_valid); end
    step();
    n_chk++; if (bus.pc !== 32'h28 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL resume_next pc %h flush %b want 28/0", bus.pc, bus.flush); end
  endtask

  task automatic test_jump_halt_reset();
    bus.JmpSel = 1; bus.halt = 1; bus.jmp_target = 32'h80;
    step();
    bus.JmpSel = 0; bus.halt = 0;
    n_chk++; if (bus.pc !== 32'h80 || bus.halted !== 1'b0 || bus.flush !== 1'b1)
      begin n_fail++; $display("FAIL jump_beats_halt pc %h halted %b flush %b want 80/0/1", bus.pc, bus.halted, bus.flush); end
    rst = 1;
    step();
    rst = 0;
    n_chk++; if (bus.pc !== 32'h0 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL rst_in_flush pc %h flush %b want 0/0", bus.pc, bus.flush); end
    step();
    n_chk++; if (bus.pc !== 32'h4 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL rst_flush_after pc %h flush %b want 4/0", bus.pc, bus.flush); end
    bus.stall = 1; bus.JmpSel = 1; bus.jmp_target = 32'h500;
    step();
    bus.JmpSel = 0; rst = 1;
    step();
    rst = 0; bus.stall = 0;
    step();
    n_chk++; if (bus.pc !== 32'h4 || bus.flush !== 1'b0) begin n_fail++; $display("FAIL rst_drops_pend pc %h flush %b want 4/0", bus.pc, bus.flush); end
  endtask

  task automatic test_wrap();
    bus8.JmpSel = 1; bus8.jmp_target = 8'hFC;
    step();
    bus8.JmpSel = 0;
    n_chk++; if (bus8.pc !== 8'hFC || bus8.pc_plus4 !== 8'h00) begin n_fail++; $display("FAIL wrap_pre pc %h p4 %h want fc/00", bus8.pc, bus8.pc_plus4); end
    step();
    n_chk++; if (bus8.pc !== 8'h00 || bus8.pc_plus4 !== 8'h04) begin n_fail++; $display("FAIL wrap pc %h p4 %h want 00/04", bus8.pc, bus8.pc_plus4); end
  endtask

`ifdef PC_REDIRECT_STATS_EN
  task automatic test_stats();
    rst = 1;
    step();
    rst = 0;
    n_chk++; if (bus.taken_cnt !== 16'd0 || bus.flush_cyc !== 16'd0) begin n_fail++; $display("FAIL stats_reset taken %0d fcyc %0d want 0/0", bus.taken_cnt, bus.flush_cyc); end
    for (int i = 0; i < 3; i++) begin
      bus.JmpSel = 1; bus.jmp_target = 32'h1000 + 32'(i * 16);
      step();
      bus.JmpSel = 0;
      step();
      step();
    end
    n_chk++; if (bus.taken_cnt !== 16'd3 || bus.flush_cyc !== 16'd6) begin n_fail++; $display("FAIL stats taken %0d fcyc %0d want 3/6", bus.taken_cnt, bus.flush_cyc); end
  endtask
`endif

  initial begin
    test_reset();
    test_jump();
    test_stall_jump();
    test_halt();
    test_jump_halt_reset();
    test_wrap();
`ifdef PC_REDIRECT_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Consumer of the condition unit's jump decision (JmpSel).
- Owns the program counter and redirects fetch to a branch target when a jump is taken.
- Squashes wrong-path instructions already in the front-end pipeline, and honours fetch stalls and a halt instruction.
- Sits between the condition unit / decode stage and instruction memory in the vector ASIP.

Parameters:
PC_W, 32, program counter width in bits
RESET_PC, 0, PC value loaded on reset
FLUSH_STAGES, 2, number of wrong-path pipeline slots to squash after a redirect (1..7)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  front-end stall; PC holds while high
JmpSel  input  1  taken-jump decision from condition unit, valid for one cycle
jmp_target  input  PC_W  branch target, valid when JmpSel=1
halt  input  1  decoded halt instruction, one-cycle pulse
resume  input  1  leave HALT state, one-cycle pulse
pc  output  PC_W  current fetch address
pc_plus4  output  PC_W  pc+4, wraps modulo 2^PC_W
flush  output  1  squash the instruction currently in the decode/execute slots
fetch_valid  output  1  pc is a valid fetch request this cycle
halted  output  1  core is halted

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: pc=RESET_PC, flush=0, fetch_valid=0 for the reset cycle, halted=0, state=RUN, pending redirect cleared. fetch_valid=1 from the first cycle after rst falls.
- Reset mid-flush or mid-halt: state returns to RUN immediately and the pending target is discarded.
- States: RUN, FLUSH, HALT.
- RUN:
  - JmpSel=1 and stall=0: pc<=jmp_target next cycle; go to FLUSH with flush_cnt=FLUSH_STAGES.
  - JmpSel=0 and stall=0: pc<=pc+4.
  - stall=1: pc holds.
- Jump during stall:
  - JmpSel=1 with stall=1 latches jmp_target into pend_tgt and sets pend=1.
  - pc<=pend_tgt on the first cycle with stall=0, then FLUSH.
  - A redirect is never lost.
  - A second JmpSel while pend=1 overwrites pend_tgt (latest wins).
- FLUSH:
  - flush=1 while flush_cnt>0.
  - flush_cnt decrements only when stall=0; pc advances +4 normally.
  - At flush_cnt=1 with stall=0, return to RUN.
  - JmpSel=1 during FLUSH redirects again and reloads flush_cnt=FLUSH_STAGES.
- Halt:
  - halt=1 (RUN or FLUSH, stall=0) enters HALT.
  - pc holds at the halt address +4; fetch_valid=0; halted=1; flush=0.
  - halt has lower priority than JmpSel in the same cycle: jump wins and halt is ignored.
- HALT:
  - Ignores JmpSel and stall.
  - resume=1 -> RUN next cycle, fetch_valid=1, pc unchanged.
- Latency: JmpSel to new pc = 1 cycle (no stall). flush asserts in the same cycle pc shows the target.
- Arithmetic: pc+4 is unsigned, modulo 2^PC_W; wrap from max-3 to 0 is legal and silent.

Optional Feature:
- Macro: PC_REDIRECT_STATS_EN.
- Defined:
  - Adds output taken_cnt[15:0], counting accepted redirects.
  - Adds output flush_cyc[15:0], counting cycles with flush=1.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pc_redirect_pkg:
  - typedef enum logic [1:0] {RUN, FLUSH, HALT} redirect_state_t;
  - localparam PC_INC=4;
  - typedef for the flush counter width (3 bits).
- One natural sub-module: pc_reg, the PC flip-flop with load/increment/hold muxing, instantiated once. FSM and pending latch stay in the top.

Test Plan:
- Reset: rst=1 for 1 cycle -> pc=0, flush=0, halted=0; then 3 free cycles -> pc=4,8,12, fetch_valid=1.
- Taken jump: JmpSel=1, jmp_target=0x100 at pc=0x10 -> next cycle pc=0x100, flush=1 for 2 cycles (FLUSH_STAGES=2), then pc=0x108 in RUN.
- Jump under stall: stall=1, JmpSel=1, target=0x40; hold stall 3 cycles -> pc unchanged throughout; first unstalled cycle -> pc=0x40, flush=1.
- Halt/resume: halt=1 at pc=0x20 -> halted=1, fetch_valid=0, pc=0x24 held 5 cycles ignoring JmpSel; resume=1 -> RUN, pc=0x24 then 0x28.
- Jump+halt same cycle, target=0x80 -> pc=0x80, halted=0; rst during FLUSH -> pc=RESET_PC, flush=0 next cycle.
- Wrap: PC_W=8, pc=0xFC -> next pc=0x00, pc_plus4=0x04; with PC_REDIRECT_STATS_EN, 3 jumps -> taken_cnt=3, flush_cyc=6.
